// File: rtl/zero_pad_removal_pkg.sv
// Shared OFDM framing constants and state encoding for the
// zero-pad insertion (tx) and removal (rx) stages.
package zero_pad_removal_pkg;

  localparam int OFDM_DATA_W = 16;
  localparam int OFDM_N_TOT  = 128;
  localparam int OFDM_PAD    = 32;
  localparam int OFDM_DATA_LEN = OFDM_N_TOT - 2 * OFDM_PAD;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    DATA,
    TAIL
  } zpr_state_t;

endpackage

// File: rtl/zero_pad_removal_out_reg.sv
// One-deep valid/ready register slice carrying {sof, eof, i, q}.
// Full throughput when the consumer is always ready.
module zp_out_reg #(
  parameter int W = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  output logic         ready,
  output logic         valid,
  input  logic         take,
  output logic [W-1:0] held
);

  assign ready = !valid | take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      held  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      held  <= data;
    end else if (take) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/zero_pad_removal.sv
// Rx zero-pad removal: strips PAD guard bins at each end of an
// N_TOT-sample frame and flags nonzero guard content per frame.
module zero_pad_removal
  import zero_pad_removal_pkg::*;
#(
  parameter int DATA_W = OFDM_DATA_W,
  parameter int N_TOT  = OFDM_N_TOT,
  parameter int PAD    = OFDM_PAD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eof,
  output logic [DATA_W-1:0] out_i,
  output logic [DATA_W-1:0] out_q,
  output logic              frame_done,
  output logic              pad_err,
  output logic              frame_abort
);

  localparam int DATA_LEN = N_TOT - 2 * PAD;
  localparam int CW = $clog2(N_TOT);
  localparam int OW = 2 * DATA_W + 2;

  localparam logic [CW-1:0] LEAD_END = CW'(PAD - 1);
  localparam logic [CW-1:0] DATA_BEG = CW'(PAD);
  localparam logic [CW-1:0] DATA_END = CW'(PAD + DATA_LEN - 1);
  localparam logic [CW-1:0] LAST     = CW'(N_TOT - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  zpr_state_t state;
  logic [CW-1:0] cnt;
  logic err;

  logic slot_ready;
  logic acc;
  logic nz;
  logic load;
  logic [OW-1:0] ld_data;
  logic [OW-1:0] o_data;

  assign in_ready = (state == DATA) ? slot_ready : 1'b1;
  assign acc = in_valid & in_ready;
  assign nz = (in_i != '0) | (in_q != '0);
  assign load = acc & !in_sof & (state == DATA);
  assign ld_data = {cnt == DATA_BEG, cnt == DATA_END, in_i, in_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      err         <= 1'b0;
      frame_done  <= 1'b0;
      pad_err     <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      pad_err     <= 1'b0;
      frame_abort <= 1'b0;
      if (acc) begin
        if (in_sof) begin
          // any sof restarts the frame; mid-frame it also aborts
          frame_abort <= (state != IDLE);
          cnt         <= ONE;
          err         <= nz;
          state       <= (PAD == 1) ? DATA : LEAD;
        end else begin
          unique case (state)
            IDLE: begin
              cnt <= '0;
            end
            LEAD: begin
              err <= err | nz;
              cnt <= cnt + 1'b1;
              if (cnt == LEAD_END) state <= DATA;
            end
            DATA: begin
              cnt <= cnt + 1'b1;
              if (cnt == DATA_END) state <= TAIL;
            end
            TAIL: begin
              err <= err | nz;
              if (cnt == LAST) begin
                frame_done <= 1'b1;
                pad_err    <= err | nz;
                cnt        <= '0;
                state      <= IDLE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  zp_out_reg #(
    .W(OW)
  ) u_out (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (ld_data),
    .ready(slot_ready),
    .valid(out_valid),
    .take (out_ready),
    .held (o_data)
  );

  assign {out_sof, out_eof, out_i, out_q} = o_data;

endmodule
